// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock, valid/ready on both sides.
// Optional macro BIN2BCD_LZB_EN adds the registered leading-zero-blank flags output lzb.
module bin2bcd_seq #(
  parameter int DW = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*ND-1:0] bcd,
`ifdef BIN2BCD_LZB_EN
  output logic [ND-1:0]   lzb,
`endif
  output logic            busy
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   bin_q, bin_d;
  logic [4*ND-1:0] scr_q, scr_d;
  logic [4*ND-1:0] bcd_q, bcd_d;
  logic [4*ND-1:0] adj_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, out_valid_q, busy_q;

  // Digits >= 5 get +3 before the shift; every digit is adjusted independently.
  function automatic logic [4*ND-1:0] add3(input logic [4*ND-1:0] s);
    logic [4*ND-1:0] r;
    r = s;
    for (int k = 0; k < ND; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef BIN2BCD_LZB_EN
  logic [ND-1:0] lzb_q;

  // Flag k is set when digit k and everything above it is zero; digit 0 is never blanked.
  function automatic logic [ND-1:0] blank(input logic [4*ND-1:0] d);
    logic [ND-1:0] r;
    logic          hz;
    r  = '0;
    hz = 1'b1;
    for (int k = ND - 1; k >= 0; k--) begin
      hz = hz & (d[4*k +: 4] == 4'd0);
      if (k > 0) r[k] = hz;
    end
    return r;
  endfunction
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    adj_s   = add3(scr_q);
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = CW'(DW);
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        {scr_d, bin_d} = {adj_s, bin_q} << 1;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          bcd_d   = scr_d;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      scr_q       <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scr_q       <= scr_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

`ifdef BIN2BCD_LZB_EN
  // Blank flags follow bcd on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzb_q <= '0;
    end else begin
      lzb_q <= blank(bcd_d);
    end
  end

  assign lzb = lzb_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, backpressure, reset, back-to-back and random values.
// Define BIN2BCD_LZB_EN for both bench and RTL to also check the blank flags.
module tb_bin2bcd_seq;

  localparam int DW = 8;
  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] bin;
  logic          out_valid;
  logic          out_ready;
  logic [11:0]   bcd;
  logic          busy;
`ifdef BIN2BCD_LZB_EN
  logic [2:0]    lzb;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_seq #(.DW(DW), .ND(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
`ifdef BIN2BCD_LZB_EN
    .lzb       (lzb),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [11:0] exp_bcd;
    logic [2:0]  exp_lzb;
    int          hold;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [11:0] bcd_model(input int v);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit k and all above are zero exactly when v < 10^k.
  function automatic logic [2:0] lzb_model(input int v);
    logic [2:0] r;
    int         p;
    r = '0;
    p = 10;
    for (int k = 1; k < ND; k++) begin
      r[k] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic do_conv(input string tag, input logic [7:0] b, input logic [11:0] eb,
                         input logic [2:0] el, input int hold);
    int          lat;
    logic        busy_ok;
    logic        stable_ok;
    logic [11:0] held;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    bin       = b;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    bin      = 8'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(DW));
    check({tag, "_bcd"}, 32'(bcd), 32'(eb));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
`ifdef BIN2BCD_LZB_EN
    check({tag, "_lzb"}, 32'(lzb), 32'(el));
`endif
    held      = bcd;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      bin      = 8'($urandom);
      @(negedge clk);
      if (!out_valid || in_ready || !busy || bcd !== held) stable_ok = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_hold_stable"}, 32'(stable_ok), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_release_busy"}, 32'(busy), 32'd0);
    check({tag, "_release_bcd"}, 32'(bcd), 32'(eb));
  endtask

  initial begin
    int          acc[$];
    logic [11:0] res[$];
    int          v;

    vecs[0] = '{8'd0,   12'h000, 3'b110, 0};
    vecs[1] = '{8'd255, 12'h255, 3'b000, 0};
    vecs[2] = '{8'd100, 12'h100, 3'b000, 0};
    vecs[3] = '{8'd9,   12'h009, 3'b110, 0};
    vecs[4] = '{8'd173, 12'h173, 3'b000, 20};
    vecs[5] = '{8'd7,   12'h007, 3'b110, 0};
    vecs[6] = '{8'd50,  12'h050, 3'b100, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin       = '0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef BIN2BCD_LZB_EN
    check("rst_lzb", 32'(lzb), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_conv($sformatf("vec%0d", i), vecs[i].b, vecs[i].exp_bcd, vecs[i].exp_lzb, vecs[i].hold);
    end

    // Reset asserted after three SHIFT edges of a conversion of 200.
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_conv("after_rst", 8'd42, 12'h042, 3'b100, 0);

    // Back-to-back with in_valid held high and out_ready high.
    @(negedge clk);
    in_valid  = 1'b1;
    bin       = 8'd12;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (acc.size() == 1) bin = 8'd99;
      if (acc.size() == 2) in_valid = 1'b0;
      if (in_valid && in_ready) acc.push_back(c);
      if (out_valid) res.push_back(bcd);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) check("b2b_spacing", 32'(acc[1] - acc[0]), 32'(DW + 2));
    check("b2b_results", 32'(res.size()), 32'd2);
    if (res.size() == 2) begin
      check("b2b_first", 32'(res[0]), 32'h012);
      check("b2b_second", 32'(res[1]), 32'h099);
    end

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 255));
      do_conv($sformatf("rnd%0d_%0d", i, v), 8'(v), bcd_model(v), lzb_model(v), (i % 5 == 0) ? 3 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
- Sits directly downstream of the combinational divider and consumes its quotient or remainder.
- Produces packed BCD digits for decimal display and readout.
- Valid/ready on both sides. One conversion in flight at a time.

Parameters:
- DW, 8: binary input width; matches the divider's DW.
- ND, 3: number of BCD output digits. Must satisfy 10^ND > 2^DW-1. Not checked in RTL.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bin holds a value to convert.
- in_ready  output  1  block can accept; high only in IDLE.
- bin  input  DW  unsigned binary operand, sampled on accept.
- out_valid  output  1  bcd is valid and stable.
- out_ready  input  1  consumer takes bcd.
- bcd  output  4*ND  packed BCD; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
- busy  output  1  high in SHIFT and DONE.

Behaviour:
- Reset: rst_n low asynchronously forces IDLE, whatever the current state (including mid-SHIFT). All outputs reset to 0: in_ready=0 during reset, bcd=0, out_valid=0, busy=0. Internal shift register and counter clear to 0.
- First cycle after reset release: IDLE with in_ready=1.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready:
    - latch bin into the binary shift register;
    - clear the BCD scratch register;
    - load the counter with DW;
    - go to SHIFT.
- State SHIFT, once per edge:
  - Each 4-bit scratch digit >=5 gets +3. All digits are adjusted in parallel from pre-shift values.
  - Then shift {scratch, binary} left by 1; the binary MSB enters scratch bit 0.
  - Decrement the counter.
  - When the counter reaches 0 on this edge, go to DONE and copy scratch into bcd.
  - The digit adjust never carries between digits; each digit stays in 0..9 after the shift.
- State DONE:
  - out_valid=1; bcd held stable.
  - On out_valid&&out_ready: go to IDLE, clear out_valid, keep bcd at its last value.
  - out_ready low holds DONE indefinitely with no change.
- Latency:
  - Accept at edge T.
  - out_valid first high after edge T+DW.
  - Minimum accept-to-accept spacing is DW+2 cycles.
- Simultaneous events:
  - in_valid while busy is ignored; in_ready=0, so no accept.
  - In DONE, out_ready and in_valid in the same cycle: only the output handshake completes. The new input is accepted in the following IDLE cycle.
- Boundary values:
  - bin=0 gives bcd=all zeros.
  - bin=2^DW-1 gives the correct decimal value, provided ND satisfies its constraint.
  - The counter must not wrap; DW=1 must work (one SHIFT cycle).
- bin is only sampled at accept; changes during SHIFT have no effect.

Optional Feature:
- Macro: BIN2BCD_LZB_EN.
- When defined:
  - Adds output port lzb, width ND, registered alongside bcd.
  - lzb[k]=1 when digit k and all higher digits are zero. Digit 0 is never blanked, so lzb[0]=0 always.
  - lzb reset value is 0; it updates on the same edge as bcd.
- When undefined: no lzb port, no extra logic. All other behaviour identical.

Test Plan:
- Reset, then bin=8'd0 with in_valid -> out_valid high 8 cycles after the accept edge; bcd=12'h000; busy high throughout.
- bin=8'd255 -> bcd=12'h255. bin=8'd100 -> bcd=12'h100. bin=8'd9 -> bcd=12'h009.
- Backpressure: convert 8'd173, hold out_ready=0 for 20 cycles -> bcd=12'h173 and out_valid stable; in_ready=0 and in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle.
- Reset mid-conversion: accept 8'd200, assert rst_n low after 3 SHIFT cycles -> outputs 0 immediately. After release, accept 8'd42 -> bcd=12'h042 with no residue from 200.
- Back-to-back: in_valid held high with 8'd12 then 8'd99, out_ready=1 -> two results, 12'h012 then 12'h099; second accept occurs exactly DW+2 cycles after the first.
- With BIN2BCD_LZB_EN: bin=7 -> lzb=3'b110; bin=0 -> 3'b110; bin=50 -> 3'b100; bin=255 -> 3'b000.
